// File: rtl/udp_rx_pkg.sv
// Shared types and constants for the UDP receive to DAC FIFO unpacker.
package udp_rx_pkg;

    localparam int HDR_BYTES = 4;
    localparam int CNT_W     = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2,
        ST_DROP = 2'd3
    } state_e;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                                 input logic [1:0]       inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, cnt} + {{(CNT_W-1){1'b0}}, inc};
        sat_add = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/byte_packer_32.sv
// Packs bytes little-endian into 32-bit words; flush discards any partial word.
module byte_packer_32 (
    input  logic        clk125,
    input  logic        clk125_srst,
    input  logic        flush,
    input  logic        byte_vld,
    input  logic [7:0]  byte_in,
    output logic        last_byte,
    output logic [31:0] word
);

    logic [1:0]  idx_q, idx_d;
    logic [23:0] shreg_q, shreg_d;

    always_ff @(posedge clk125) begin
        if (clk125_srst) begin
            idx_q   <= '0;
            shreg_q <= '0;
        end else begin
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
        end
    end

    always_comb begin
        idx_d   = idx_q;
        shreg_d = shreg_q;
        if (flush) begin
            idx_d = '0;
        end else if (byte_vld) begin
            idx_d   = idx_q + 2'd1;
            shreg_d = {byte_in, shreg_q[23:8]};
        end
    end

    // Earlier bytes have shifted down, so the current byte lands in [31:24].
    assign last_byte = (idx_q == 2'd3);
    assign word      = {byte_in, shreg_q};

endmodule

// File: rtl/udp_rx_dac_unpacker.sv
// Unpacks sequence-numbered UDP payloads into 32-bit DAC FIFO writes.
// Define UDP_RX_SEQ_CHECK_EN to enable sequence gap counting.
//
// state | meaning
// IDLE  | waiting for rx_sop
// HDR   | consuming the 4-byte sequence number
// DATA  | packing payload into words
// DROP  | discarding bytes until rx_eop
module udp_rx_dac_unpacker
    import udp_rx_pkg::*;
#(
    parameter int MAX_WORDS = 256,
    parameter int FREE_W    = 10
) (
    input  logic              clk125,
    input  logic              clk125_srst,
    input  logic [7:0]        rx_byte,
    input  logic              rx_vld,
    input  logic              rx_sop,
    input  logic              rx_eop,
    input  logic              rx_err,
    input  logic [FREE_W-1:0] dac_fifo_free,
    output logic              dac_fifo_wren,
    output logic [31:0]       dac_fifo_wdata,
    output logic [CNT_W-1:0]  pkt_ok_cnt,
    output logic [CNT_W-1:0]  pkt_drop_cnt,
    output logic [CNT_W-1:0]  pkt_err_cnt,
    output logic [CNT_W-1:0]  seq_gap_cnt
);

    localparam int WCW = $clog2(MAX_WORDS + 1);

    state_e           state_q, state_d;
    logic [1:0]       hdr_cnt_q, hdr_cnt_d;
    logic [WCW-1:0]   word_cnt_q, word_cnt_d;
    logic             wren_q, wren_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [CNT_W-1:0] ok_q, ok_d, drop_q, drop_d, err_q, err_d;
    logic             ok_inc, drop_inc;
    logic [1:0]       err_inc;
    logic             space_ok, words_full;
    logic             pk_vld, pk_flush, pk_last;
    logic [31:0]      pk_word;
`ifdef UDP_RX_SEQ_CHECK_EN
    logic [23:0]      seq_q, seq_d;
    logic [31:0]      exp_q, exp_d, seq_full;
    logic             exp_vld_q, exp_vld_d, gap_inc;
    logic [CNT_W-1:0] gap_q, gap_d;
`endif

    byte_packer_32 u_packer (
        .clk125      (clk125),
        .clk125_srst (clk125_srst),
        .flush       (pk_flush),
        .byte_vld    (pk_vld),
        .byte_in     (rx_byte),
        .last_byte   (pk_last),
        .word        (pk_word)
    );

    always_ff @(posedge clk125) begin
        if (clk125_srst) begin
            state_q    <= ST_IDLE;
            hdr_cnt_q  <= '0;
            word_cnt_q <= '0;
            wren_q     <= 1'b0;
            wdata_q    <= '0;
            ok_q       <= '0;
            drop_q     <= '0;
            err_q      <= '0;
`ifdef UDP_RX_SEQ_CHECK_EN
            seq_q      <= '0;
            exp_q      <= '0;
            exp_vld_q  <= 1'b0;
            gap_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            hdr_cnt_q  <= hdr_cnt_d;
            word_cnt_q <= word_cnt_d;
            wren_q     <= wren_d;
            wdata_q    <= wdata_d;
            ok_q       <= ok_d;
            drop_q     <= drop_d;
            err_q      <= err_d;
`ifdef UDP_RX_SEQ_CHECK_EN
            seq_q      <= seq_d;
            exp_q      <= exp_d;
            exp_vld_q  <= exp_vld_d;
            gap_q      <= gap_d;
`endif
        end
    end

    assign space_ok   = (32'(dac_fifo_free) >= 32'(MAX_WORDS));
    assign words_full = (word_cnt_q == WCW'(MAX_WORDS));

    always_comb begin
        state_d    = state_q;
        hdr_cnt_d  = hdr_cnt_q;
        word_cnt_d = word_cnt_q;
        ok_inc     = 1'b0;
        drop_inc   = 1'b0;
        err_inc    = 2'd0;
`ifdef UDP_RX_SEQ_CHECK_EN
        seq_d      = seq_q;
        exp_d      = exp_q;
        exp_vld_d  = exp_vld_q;
        gap_inc    = 1'b0;
        seq_full   = {seq_q, rx_byte};
`endif
        if (rx_vld) begin
            if (rx_sop) begin
                // A SOP mid-packet aborts it, then restarts as if from IDLE.
                if (state_q == ST_HDR || state_q == ST_DATA)
                    err_inc = err_inc + 2'd1;
                if (space_ok) begin
                    hdr_cnt_d = 2'd1;
`ifdef UDP_RX_SEQ_CHECK_EN
                    seq_d = {16'h0, rx_byte};
`endif
                    if (rx_eop) begin
                        err_inc = err_inc + 2'd1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_HDR;
                    end
                end else begin
                    drop_inc = 1'b1;
                    state_d  = rx_eop ? ST_IDLE : ST_DROP;
                end
            end else begin
                case (state_q)
                    ST_HDR: begin
                        if (rx_eop) begin
                            err_inc = 2'd1;
                            state_d = ST_IDLE;
                        end else begin
                            hdr_cnt_d = hdr_cnt_q + 2'd1;
`ifdef UDP_RX_SEQ_CHECK_EN
                            seq_d = {seq_q[15:0], rx_byte};
`endif
                            if (hdr_cnt_q == 2'(HDR_BYTES - 1)) begin
                                state_d    = ST_DATA;
                                word_cnt_d = '0;
`ifdef UDP_RX_SEQ_CHECK_EN
                                gap_inc   = exp_vld_q && (seq_full != exp_q);
                                exp_d     = seq_full + 32'd1;
                                exp_vld_d = 1'b1;
`endif
                            end
                        end
                    end
                    ST_DATA: begin
                        if (words_full) begin
                            err_inc = 2'd1;
                            state_d = rx_eop ? ST_IDLE : ST_DROP;
                        end else begin
                            if (pk_last)
                                word_cnt_d = word_cnt_q + WCW'(1);
                            if (rx_eop) begin
                                state_d = ST_IDLE;
                                if (rx_err || !pk_last)
                                    err_inc = 2'd1;
                                else
                                    ok_inc = 1'b1;
                            end
                        end
                    end
                    ST_DROP: begin
                        if (rx_eop)
                            state_d = ST_IDLE;
                    end
                    default: ;
                endcase
            end
        end
        ok_d   = sat_add(ok_q, {1'b0, ok_inc});
        drop_d = sat_add(drop_q, {1'b0, drop_inc});
        err_d  = sat_add(err_q, err_inc);
`ifdef UDP_RX_SEQ_CHECK_EN
        gap_d  = sat_add(gap_q, {1'b0, gap_inc});
`endif
    end

    always_comb begin
        pk_flush = (state_q != ST_DATA);
        pk_vld   = rx_vld && !rx_sop && (state_q == ST_DATA) && !words_full;
        wren_d   = pk_vld && pk_last;
        wdata_d  = wren_d ? pk_word : wdata_q;
    end

    assign dac_fifo_wren  = wren_q;
    assign dac_fifo_wdata = wdata_q;
    assign pkt_ok_cnt     = ok_q;
    assign pkt_drop_cnt   = drop_q;
    assign pkt_err_cnt    = err_q;
`ifdef UDP_RX_SEQ_CHECK_EN
    assign seq_gap_cnt    = gap_q;
`else
    assign seq_gap_cnt    = '0;
`endif

endmodule

// File: doc/udp_rx_dac_unpacker.md
UDP_RX_DAC_UNPACKER -- requirements
Module: udp_rx_dac_unpacker

Interface
REQ-001 SHALL have parameter MAX_WORDS, default 256, meaning the maximum number of payload words accepted per packet.
REQ-002 SHALL have parameter FREE_W, default 10, meaning the width of the FIFO free-space count.
REQ-003 SHALL have `clk125  in  1`, the single clock; all logic is clocked on its rising edge.
REQ-004 SHALL have `clk125_srst  in  1`, the reset, which is synchronous and active-high.
REQ-005 SHALL have `rx_byte  in  8`, the MAC receive byte.
REQ-006 SHALL have `rx_vld  in  1`, which qualifies rx_byte, rx_sop, rx_eop and rx_err.
REQ-007 SHALL have `rx_sop  in  1`, marking the first byte of a packet.
REQ-008 SHALL have `rx_eop  in  1`, marking the last byte of a packet.
REQ-009 SHALL have `rx_err  in  1`, the MAC bad-frame flag, valid with rx_eop.
REQ-010 SHALL have `dac_fifo_free  in  FREE_W`, the free word count of the downstream DAC FIFO.
REQ-011 SHALL have `dac_fifo_wren  out  1`, the DAC FIFO write strobe.
REQ-012 SHALL have `dac_fifo_wdata  out  32`, the DAC FIFO write word.
REQ-013 SHALL have `pkt_ok_cnt  out  16`, counting accepted packets.
REQ-014 SHALL have `pkt_drop_cnt  out  16`, counting packets dropped for lack of FIFO space.
REQ-015 SHALL have `pkt_err_cnt  out  16`, counting rx_err, truncated, runt and aborted packets.
REQ-016 SHALL have `seq_gap_cnt  out  16`, counting sequence discontinuities.

Function
REQ-017 Packet format SHALL be a 4-byte big-endian sequence number followed by the payload; payload bytes are packed little-endian (first byte to [7:0], fourth byte to [31:24]).
REQ-018 The state machine SHALL have states IDLE, HDR, DATA and DROP.
REQ-019 In IDLE, bytes without rx_sop SHALL be ignored.
REQ-020 On rx_vld & rx_sop in IDLE: if dac_fifo_free >= MAX_WORDS, go to HDR; otherwise increment pkt_drop_cnt and go to DROP.
REQ-021 HDR SHALL consume exactly 4 bytes (SOP byte included), then go to DATA.
REQ-022 rx_eop while in HDR SHALL increment pkt_err_cnt (runt) and return to IDLE.
REQ-023 In DATA, each complete 4-byte group SHALL produce one dac_fifo_wren pulse, registered, asserted in the cycle after the fourth byte is accepted.
REQ-024 The write count SHALL never exceed MAX_WORDS per packet.
REQ-025 A byte arriving after MAX_WORDS words SHALL cause truncation: increment pkt_err_cnt and go to DROP (or to IDLE if that byte carries rx_eop).
REQ-026 On rx_eop in DATA with rx_err=0 and no partial word pending, increment pkt_ok_cnt.
REQ-027 On rx_eop in DATA with a 1-3 byte partial word, discard the partial bytes and increment pkt_err_cnt.
REQ-028 On rx_eop in DATA with rx_err=1, increment pkt_err_cnt; words already written are not retracted.
REQ-029 DROP SHALL discard bytes until rx_eop, then go to IDLE.
REQ-030 An rx_sop arriving in HDR, DATA or DROP SHALL abort the current packet (pkt_err_cnt +1 unless in DROP), discard any partial word, and be treated as a new SOP from IDLE in the same cycle.
REQ-031 A single byte carrying both rx_sop and rx_eop SHALL count as a runt error.
REQ-032 All counters SHALL saturate at 16'hFFFF.
REQ-033 dac_fifo_wdata SHALL be held stable whenever dac_fifo_wren=0.

Reset
REQ-034 While clk125_srst=1, the FSM SHALL be in IDLE, all outputs and counters 0, the byte index 0, and the expected sequence number invalid.
REQ-035 Reset asserted mid-packet SHALL take effect on the next edge; bytes following deassertion without rx_sop are ignored.

Configuration
REQ-036 With UDP_RX_SEQ_CHECK_EN defined: the first accepted packet after reset loads expected = seq+1 with no gap counted; each later accepted header with seq != expected increments seq_gap_cnt once; expected is always reloaded as seq+1; seq wraps 32'hFFFFFFFF -> 0 without counting a gap.
REQ-037 Without UDP_RX_SEQ_CHECK_EN: header bytes SHALL be skipped unchecked and seq_gap_cnt SHALL be tied to 0.

Structure
REQ-038 Package udp_rx_pkg SHALL hold the state enum, HDR_BYTES=4 and the counter width constant.
REQ-039 One sub-module, byte_packer_32 (byte-to-word shift, index and flush), SHALL be used.

Verification
REQ-040 Normal packet: free=512, seq=0, payload 00 00 00 00 01 00 00 00 -> writes 0x00000000 then 0x00000001; pkt_ok_cnt=1.
REQ-041 No space: free=100 at SOP -> no writes; pkt_drop_cnt=1; the next packet with free=256 is accepted.
REQ-042 Partial word and error: 6-byte payload -> 1 write, pkt_err_cnt=1; 8-byte payload with rx_err -> 2 writes, pkt_err_cnt=2.
REQ-043 Sequence: seqs 5, 6, 9, 10 -> seq_gap_cnt=1; seqs FFFFFFFF, 0 -> no gap (macro defined); macro undefined -> seq_gap_cnt=0 throughout.
REQ-044 Overlength and abort: payload of 1025 words -> exactly 256 writes, pkt_err_cnt=1; SOP at payload byte 2 -> 0 writes from the first packet, second packet accepted normally.
REQ-045 Reset mid-DATA after 2 words -> no further writes; the next SOP packet decodes correctly.
